// File: rtl/eth_rx_frame_fifo.sv
// Purpose : store-and-forward receive buffer behind the Ethernet MAC receive stream.
//           Only complete good frames are released downstream; frames flagged bad by
//           the MAC or that run out of buffer space are discarded.
// Latency : tlast beat in cycle N -> first byte valid on m_axis in cycle N+2.
// Backpressure: input side has none (every beat is taken or dropped); output side
//           honours m_axis_tready with a 2-entry output stage, 1 byte/cycle when ready.
//
// Ports:
//   rx_mac_aclk, glbl_rst           clock, asynchronous active-high reset
//   s_axis_rx_*                     MAC receive stream (no ready), tuser = bad on tlast
//   m_axis_*                        buffered frame stream towards packet processing
//   frames_good/bad/ovf_cnt         saturating frame statistics
module eth_rx_frame_fifo #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 rx_mac_aclk,
  input  logic                 glbl_rst,
  input  logic [7:0]           s_axis_rx_tdata,
  input  logic                 s_axis_rx_tvalid,
  input  logic                 s_axis_rx_tlast,
  input  logic                 s_axis_rx_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [CNT_WIDTH-1:0] frames_good_cnt,
  output logic [CNT_WIDTH-1:0] frames_bad_cnt,
  output logic [CNT_WIDTH-1:0] frames_ovf_cnt
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Occupancy value that means "every RAM slot holds a byte".
  localparam logic [PW-1:0] FULL_OCC = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Write-side frame states.
  localparam logic [1:0] ST_WAIT_GAP = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_RECV     = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  // ---------------------------------------------------------------------------
  // Reset conditioning: assertion is immediate, release is retimed to the clock
  // so every flop leaves reset on the same edge.
  // ---------------------------------------------------------------------------
  logic rst_meta_q;
  logic rst_q;

  always_ff @(posedge rx_mac_aclk or posedge glbl_rst) begin
    if (glbl_rst) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State declarations
  // ---------------------------------------------------------------------------
  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;

  logic [8:0]           skid0_q, skid0_d;   // head entry, drives m_axis
  logic [8:0]           skid1_q, skid1_d;
  logic [1:0]           skid_cnt_q, skid_cnt_d;

  logic [CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

  logic                 wr_en;
  logic                 good_inc;
  logic                 bad_inc;
  logic                 ovf_inc;
  logic [PW-1:0]        occupancy;
  logic                 buf_full;

  logic                 pop;
  logic                 rd_avail;
  logic                 rd_issue;
  logic [8:0]           ram_rd_dat;

  // ---------------------------------------------------------------------------
  // Frame buffer RAM {tlast, tdata}. Not reset: only bytes between rd_ptr and
  // commit_ptr are ever read, and those have always been written first.
  // ---------------------------------------------------------------------------
  logic [8:0] mem [DEPTH];

  always_ff @(posedge rx_mac_aclk) begin
    if (wr_en) begin
      mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_rx_tlast, s_axis_rx_tdata};
    end
  end

  // The read address is registered-in-effect: the addressed word is captured
  // straight into the output stage on the next edge, giving one cycle of read
  // latency without an extra pipeline register in front of the skid.
  assign ram_rd_dat = mem[rd_ptr_q[ADDR_WIDTH-1:0]];

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  // Occupancy counts uncommitted bytes as well, so a frame can never overwrite
  // data that has not yet been fetched. rd_ptr is the registered value, so a
  // slot freed by this cycle's fetch only becomes usable next cycle.
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign buf_full  = (occupancy == FULL_OCC);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en        = 1'b0;
    good_inc     = 1'b0;
    bad_inc      = 1'b0;
    ovf_inc      = 1'b0;

    case (state_q)
      // After reset the MAC may be in the middle of a frame; swallow beats
      // until the first idle cycle so a truncated frame is never buffered.
      ST_WAIT_GAP: begin
        if (!s_axis_rx_tvalid) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE, ST_RECV: begin
        if (s_axis_rx_tvalid) begin
          if (!buf_full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (s_axis_rx_tlast) begin
              state_d = ST_IDLE;
              if (s_axis_rx_tuser) begin
                // Bad frame: rewind to the last commit point.
                wr_ptr_d = commit_ptr_q;
                bad_inc  = 1'b1;
              end else begin
                commit_ptr_d = wr_ptr_q + PW'(1);
                good_inc     = 1'b1;
              end
            end else begin
              state_d = ST_RECV;
            end
          end else if (s_axis_rx_tlast) begin
            wr_ptr_d = commit_ptr_q;
            ovf_inc  = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      // Frame has already lost bytes; discard the rest and rewind on tlast.
      // It counts as an overflow whatever the MAC's verdict.
      ST_DROP: begin
        if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
          wr_ptr_d = commit_ptr_q;
          ovf_inc  = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_WAIT_GAP;
    endcase
  end

  // Saturating statistics.
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (good_inc && (good_cnt_q != {CNT_WIDTH{1'b1}})) begin
      good_cnt_d = good_cnt_q + CNT_WIDTH'(1);
    end
    if (bad_inc && (bad_cnt_q != {CNT_WIDTH{1'b1}})) begin
      bad_cnt_d = bad_cnt_q + CNT_WIDTH'(1);
    end
    if (ovf_inc && (ovf_cnt_q != {CNT_WIDTH{1'b1}})) begin
      ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: prefetch committed bytes into a 2-entry output stage.
  // A fetch is issued whenever the stage will have room after this cycle's
  // transfer, which keeps a continuous stream at one byte per cycle.
  // ---------------------------------------------------------------------------
  assign pop      = (skid_cnt_q != 2'd0) && m_axis_tready;
  assign rd_avail = (rd_ptr_q != commit_ptr_q);
  assign rd_issue = rd_avail && ((skid_cnt_q != 2'd2) || pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;

    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case (skid_cnt_q)
      2'd0: begin
        if (rd_issue) begin
          skid0_d    = ram_rd_dat;
          skid_cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (pop && rd_issue) begin
          skid0_d = ram_rd_dat;
        end else if (pop) begin
          skid_cnt_d = 2'd0;
        end else if (rd_issue) begin
          skid1_d    = ram_rd_dat;
          skid_cnt_d = 2'd2;
        end
      end
      2'd2: begin
        // Head only moves on a transfer, so tdata/tlast stay stable under
        // backpressure.
        if (pop) begin
          skid0_d = skid1_q;
          if (rd_issue) begin
            skid1_d = ram_rd_dat;
          end else begin
            skid_cnt_d = 2'd1;
          end
        end
      end
      default: skid_cnt_d = 2'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge rx_mac_aclk or posedge rst_q) begin
    if (rst_q) begin
      state_q      <= ST_WAIT_GAP;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      skid0_q      <= '0;
      skid1_q      <= '0;
      skid_cnt_q   <= 2'd0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      skid_cnt_q   <= skid_cnt_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_axis_tvalid   = (skid_cnt_q != 2'd0);
  assign m_axis_tdata    = skid0_q[7:0];
  assign m_axis_tlast    = skid0_q[8];
  assign frames_good_cnt = good_cnt_q;
  assign frames_bad_cnt  = bad_cnt_q;
  assign frames_ovf_cnt  = ovf_cnt_q;

endmodule
